// File: rtl/cpu7_ifq_if.sv
// Fetch-beat and decode-head signal bundle for the instruction fetch queue.
// master: icache/redirect side driving beats; slave: the queue itself.
interface cpu7_ifq_if;
  logic         inst_valid;
  logic [127:0] inst_rdata;
  logic [1:0]   inst_count;
  logic [31:0]  inst_pc;
  logic         inst_exception;
  logic [5:0]   inst_exccode;
  logic         ifq_flush;
  logic         exu_ifu_stall_req;
  logic         ifq_can_accept;
  logic         ifu_exu_valid_d;
  logic [31:0]  ifu_exu_inst_d;
  logic [31:0]  ifu_exu_pc_d;
  logic         ifu_exu_exception_d;
  logic [5:0]   ifu_exu_exccode_d;
  logic         ifq_overflow;

  modport master (
    output inst_valid, inst_rdata, inst_count, inst_pc, inst_exception, inst_exccode,
    output ifq_flush, exu_ifu_stall_req,
    input  ifq_can_accept, ifu_exu_valid_d, ifu_exu_inst_d, ifu_exu_pc_d,
    input  ifu_exu_exception_d, ifu_exu_exccode_d, ifq_overflow
  );

  modport slave (
    input  inst_valid, inst_rdata, inst_count, inst_pc, inst_exception, inst_exccode,
    input  ifq_flush, exu_ifu_stall_req,
    output ifq_can_accept, ifu_exu_valid_d, ifu_exu_inst_d, ifu_exu_pc_d,
    output ifu_exu_exception_d, ifu_exu_exccode_d, ifq_overflow
  );
endinterface

// File: rtl/cpu7_ifq.sv
// Instruction fetch queue: accepts up to four words per beat into a circular buffer
// and presents one registered entry per cycle to decode.
module cpu7_ifq #(
  parameter int unsigned DEPTH = 8
) (
  input logic        clk,
  input logic        reset,
  cpu7_ifq_if.slave  ifq
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] DepthC = DEPTH[AW:0];

  logic [31:0] inst_mem [DEPTH];
  logic [31:0] pc_mem   [DEPTH];
  logic        exc_mem  [DEPTH];
  logic [5:0]  code_mem [DEPTH];

  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          overflow_q, overflow_d;

  logic [2:0]    beat_n;
  logic [AW:0]   free;
  logic          room, push, pop, drop;
  logic [AW-1:0] wr_idx  [4];
  logic [31:0]   wr_inst [4];
  logic [31:0]   wr_pc   [4];

  always_comb begin
    beat_n = ifq.inst_exception ? 3'd1 : {1'b0, ifq.inst_count} + 3'd1;
    free   = DepthC - count_q;
    room   = free >= (AW+1)'(beat_n);
    push   = ifq.inst_valid & ~ifq.ifq_flush & room;
    drop   = ifq.inst_valid & ~ifq.ifq_flush & ~room;
    pop    = (count_q != '0) & ~ifq.exu_ifu_stall_req & ~ifq.ifq_flush;
  end

  // Exception beats collapse to a single zero-instruction entry at word 0.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      wr_idx[i]  = wr_ptr_q + AW'(i);
      wr_inst[i] = ifq.inst_exception ? 32'h0 : ifq.inst_rdata[32*i +: 32];
      wr_pc[i]   = ifq.inst_pc + 32'(4 * i);
    end
  end

  always_comb begin
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q | drop;
    if (ifq.ifq_flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + AW'(beat_n);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q + (push ? (AW+1)'(beat_n) : '0) - (pop ? (AW+1)'(1) : '0);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Entry storage carries no reset; validity is tracked by count alone.
  always_ff @(posedge clk) begin
    if (push) begin
      for (int i = 0; i < 4; i++) begin
        if (3'(i) < beat_n) begin
          inst_mem[wr_idx[i]] <= wr_inst[i];
          pc_mem[wr_idx[i]]   <= wr_pc[i];
          exc_mem[wr_idx[i]]  <= ifq.inst_exception;
          code_mem[wr_idx[i]] <= ifq.inst_exception ? ifq.inst_exccode : 6'h0;
        end
      end
    end
  end

  always_comb begin
    ifq.ifq_can_accept      = (DepthC - count_q) >= (AW+1)'(4);
    ifq.ifu_exu_valid_d     = count_q != '0;
    ifq.ifu_exu_inst_d      = inst_mem[rd_ptr_q];
    ifq.ifu_exu_pc_d        = pc_mem[rd_ptr_q];
    ifq.ifu_exu_exception_d = exc_mem[rd_ptr_q];
    ifq.ifu_exu_exccode_d   = code_mem[rd_ptr_q];
    ifq.ifq_overflow        = overflow_q;
  end
endmodule

// File: tb/tb_cpu7_ifq.sv
// Directed bench for cpu7_ifq: drain order, full/overflow, wrap, exception beats,
// flush and asynchronous reset, all against hand-computed values.
module tb_cpu7_ifq;
  logic clk = 1'b0;
  logic reset;
  int unsigned err_cnt = 0;
  int unsigned chk_cnt = 0;

  cpu7_ifq_if ifq ();

  cpu7_ifq #(.DEPTH(8)) dut (
    .clk   (clk),
    .reset (reset),
    .ifq   (ifq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    chk_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [1:0] cnt, input logic [31:0] pc, input logic [31:0] w0,
                      input logic [31:0] w1, input logic [31:0] w2, input logic [31:0] w3);
    ifq.inst_valid     = 1'b1;
    ifq.inst_count     = cnt;
    ifq.inst_pc        = pc;
    ifq.inst_rdata     = {w3, w2, w1, w0};
    ifq.inst_exception = 1'b0;
    ifq.inst_exccode   = 6'h0;
  endtask

  task automatic idle();
    ifq.inst_valid     = 1'b0;
    ifq.inst_exception = 1'b0;
  endtask

  task automatic check_head(input string tag, input logic [31:0] inst, input logic [31:0] pc);
    check({tag, ".valid"}, 64'(ifq.ifu_exu_valid_d), 64'd1);
    check({tag, ".inst"}, 64'(ifq.ifu_exu_inst_d), 64'(inst));
    check({tag, ".pc"}, 64'(ifq.ifu_exu_pc_d), 64'(pc));
  endtask

  initial begin
    ifq.inst_valid = 1'b0;
    ifq.inst_rdata = '0;
    ifq.inst_count = '0;
    ifq.inst_pc = '0;
    ifq.inst_exception = 1'b0;
    ifq.inst_exccode = '0;
    ifq.ifq_flush = 1'b0;
    ifq.exu_ifu_stall_req = 1'b0;
    reset = 1'b1;
    #12;
    check("rst.valid", 64'(ifq.ifu_exu_valid_d), 64'd0);
    check("rst.can_accept", 64'(ifq.ifq_can_accept), 64'd1);
    check("rst.overflow", 64'(ifq.ifq_overflow), 64'd0);
    reset = 1'b0;
    tick();

    // Single 4-word beat drains in order, one per cycle.
    beat(2'd3, 32'h1c00_0000, 32'hAAAA_0001, 32'hBBBB_0002, 32'hCCCC_0003, 32'hDDDD_0004);
    tick();
    idle();
    check("b1.exc", 64'(ifq.ifu_exu_exception_d), 64'd0);
    check_head("b1.w0", 32'hAAAA_0001, 32'h1c00_0000);
    tick();
    check_head("b1.w1", 32'hBBBB_0002, 32'h1c00_0004);
    tick();
    check_head("b1.w2", 32'hCCCC_0003, 32'h1c00_0008);
    tick();
    check_head("b1.w3", 32'hDDDD_0004, 32'h1c00_000c);
    tick();
    check("b1.empty", 64'(ifq.ifu_exu_valid_d), 64'd0);

    // Fill to full under stall, then overflow on a third beat (pointers start at 4).
    ifq.exu_ifu_stall_req = 1'b1;
    beat(2'd3, 32'h0000_0100, 32'hE0, 32'hE1, 32'hE2, 32'hE3);
    tick();
    check("full.half_accept", 64'(ifq.ifq_can_accept), 64'd1);
    beat(2'd3, 32'h0000_0200, 32'hF0, 32'hF1, 32'hF2, 32'hF3);
    tick();
    check("full.can_accept", 64'(ifq.ifq_can_accept), 64'd0);
    check("full.no_ovf", 64'(ifq.ifq_overflow), 64'd0);
    beat(2'd0, 32'h0000_0300, 32'h99, 32'h0, 32'h0, 32'h0);
    tick();
    idle();
    check("ovf.flag", 64'(ifq.ifq_overflow), 64'd1);
    check_head("ovf.head", 32'hE0, 32'h0000_0100);
    ifq.exu_ifu_stall_req = 1'b0;
    for (int i = 0; i < 8; i++) begin
      check_head($sformatf("drain%0d", i), 32'(i < 4 ? 32'hE0 + i : 32'hF0 + (i - 4)),
                 32'(i < 4 ? 32'h100 + 4 * i : 32'h200 + 4 * (i - 4)));
      tick();
    end
    check("drain.empty", 64'(ifq.ifu_exu_valid_d), 64'd0);
    check("drain.ovf_sticky", 64'(ifq.ifq_overflow), 64'd1);

    // Move pointers from 4 to 6, then a 4-word beat wraps 6,7,0,1.
    beat(2'd1, 32'h0000_0400, 32'h11, 32'h12, 32'h0, 32'h0);
    tick();
    idle();
    tick();
    tick();
    beat(2'd3, 32'hffff_fff8, 32'h21, 32'h22, 32'h23, 32'h24);
    tick();
    idle();
    for (int i = 0; i < 4; i++) begin
      check_head($sformatf("wrap%0d", i), 32'h21 + 32'(i), 32'hffff_fff8 + 32'(4 * i));
      tick();
    end
    check("wrap.empty", 64'(ifq.ifu_exu_valid_d), 64'd0);

    // Exception beat collapses to one entry.
    beat(2'd2, 32'h0000_2000, 32'h31, 32'h32, 32'h33, 32'h0);
    ifq.inst_exception = 1'b1;
    ifq.inst_exccode = 6'h08;
    tick();
    idle();
    check_head("exc", 32'h0, 32'h0000_2000);
    check("exc.flag", 64'(ifq.ifu_exu_exception_d), 64'd1);
    check("exc.code", 64'(ifq.ifu_exu_exccode_d), 64'h08);
    tick();
    check("exc.single", 64'(ifq.ifu_exu_valid_d), 64'd0);

    // Flush with five entries queued and a beat arriving the same cycle.
    ifq.exu_ifu_stall_req = 1'b1;
    beat(2'd3, 32'h0000_3000, 32'h41, 32'h42, 32'h43, 32'h44);
    tick();
    beat(2'd0, 32'h0000_3010, 32'h45, 32'h0, 32'h0, 32'h0);
    tick();
    check("pre_flush.can_accept", 64'(ifq.ifq_can_accept), 64'd0);
    beat(2'd3, 32'h0000_5000, 32'h51, 32'h52, 32'h53, 32'h54);
    ifq.ifq_flush = 1'b1;
    tick();
    ifq.ifq_flush = 1'b0;
    idle();
    check("flush.valid", 64'(ifq.ifu_exu_valid_d), 64'd0);
    check("flush.can_accept", 64'(ifq.ifq_can_accept), 64'd1);
    tick();
    check("flush.dropped", 64'(ifq.ifu_exu_valid_d), 64'd0);
    ifq.exu_ifu_stall_req = 1'b0;
    beat(2'd0, 32'h0000_6000, 32'h61, 32'h0, 32'h0, 32'h0);
    tick();
    idle();
    check_head("post_flush", 32'h61, 32'h0000_6000);
    tick();

    // Asynchronous reset with three entries queued.
    ifq.exu_ifu_stall_req = 1'b1;
    beat(2'd2, 32'h0000_7000, 32'h71, 32'h72, 32'h73, 32'h0);
    tick();
    idle();
    check("pre_rst.valid", 64'(ifq.ifu_exu_valid_d), 64'd1);
    #2 reset = 1'b1;
    #1;
    check("arst.valid", 64'(ifq.ifu_exu_valid_d), 64'd0);
    check("arst.can_accept", 64'(ifq.ifq_can_accept), 64'd1);
    check("arst.overflow", 64'(ifq.ifq_overflow), 64'd0);
    #1 reset = 1'b0;
    ifq.exu_ifu_stall_req = 1'b0;
    tick();
    beat(2'd1, 32'h0000_8000, 32'h81, 32'h82, 32'h0, 32'h0);
    tick();
    idle();
    check_head("post_rst.w0", 32'h81, 32'h0000_8000);
    tick();
    check_head("post_rst.w1", 32'h82, 32'h0000_8004);
    tick();
    check("post_rst.empty", 64'(ifq.ifu_exu_valid_d), 64'd0);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end
endmodule
